// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed N-digit 7-segment scanner with blanking gap and frame-aligned updates
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dots,
  input  logic                    lz_blank,
  output logic                    ready,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] LUT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  typedef enum logic {BLANK, SHOW} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [4*NUM_DIGITS-1:0] sh_v, sh_v_n, pb_v;
  logic [NUM_DIGITS-1:0] sh_d, sh_d_n, pb_d, an_n;
  logic pend, last, wrap, lz, fd_n;
  logic [3:0] nib;
  logic [7:0] seg_n;
  assign ready = ~pend;
  // outputs are derived from the post-edge state so an/seg register together with the FSM
  always_comb begin
    last    = cnt == CW'(REFRESH_DIV - 1);
    wrap    = last && idx == IW'(NUM_DIGITS - 1);
    cnt_n   = last ? '0 : cnt + 1'b1;
    idx_n   = last ? (wrap ? '0 : idx + 1'b1) : idx;
    state_n = state == BLANK ? (cnt == CW'(BLANK_CYCLES - 1) ? SHOW : BLANK)
                             : (last && BLANK_CYCLES > 0 ? BLANK : SHOW);
    sh_v_n  = wrap && pend ? pb_v : sh_v;
    sh_d_n  = wrap && pend ? pb_d : sh_d;
    nib     = sh_v_n[{idx_n, 2'b00} +: 4];
    lz      = lz_blank && idx_n != '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (i >= int'(idx_n) && sh_v_n[i*4 +: 4] != 4'h0) lz = 1'b0;
    an_n    = state_n == SHOW ? ~(NUM_DIGITS'(1) << idx_n) : '1;
    seg_n   = state_n == SHOW ? {~sh_d_n[idx_n], lz ? 7'h7F : LUT[nib]} : 8'hFF;
    fd_n    = state_n == SHOW && cnt_n == CW'(REFRESH_DIV - 1) && idx_n == IW'(NUM_DIGITS - 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BLANK_CYCLES == 0 ? SHOW : BLANK;
      cnt        <= '0;
      idx        <= '0;
      sh_v       <= '0;
      sh_d       <= '0;
      pb_v       <= '0;
      pb_d       <= '0;
      pend       <= 1'b0;
      an         <= '1;
      seg        <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      sh_v       <= sh_v_n;
      sh_d       <= sh_d_n;
      an         <= an_n;
      seg        <= seg_n;
      frame_done <= fd_n;
      if (load && !pend) begin
        pb_v <= value;
        pb_d <= dots;
        pend <= 1'b1;
      end else if (wrap && pend) pend <= 1'b0;
    end
  end
endmodule
